// File: rtl/isp_stream_checker_if.sv
// isp_stream_checker_if
// Bundles the ISP pixel stream seen on a stage boundary so that a producer
// and any number of monitors can share one set of wires.
//
// Parameter:
//   COLOR_DEPTH  pixel width
//
// Signals:
//   pixel_in     stream data
//   valid_in     beat qualifier
//   color_in     0=VOID 1=RED 2=GREEN 3=BLUE
//   last_col_in  last beat of a row
//   last_pic_in  last beat of a frame
//
// Modports:
//   master  drives the stream (producer / bench)
//   slave   observes the stream (checker)
interface isp_stream_checker_if #(
  parameter int COLOR_DEPTH = 8
);
  logic [COLOR_DEPTH-1:0] pixel_in;
  logic                   valid_in;
  logic [1:0]             color_in;
  logic                   last_col_in;
  logic                   last_pic_in;

  modport master (
    output pixel_in,
    output valid_in,
    output color_in,
    output last_col_in,
    output last_pic_in
  );

  modport slave (
    input pixel_in,
    input valid_in,
    input color_in,
    input last_col_in,
    input last_pic_in
  );
endinterface

// File: rtl/isp_stream_checker.sv
// isp_stream_checker
// Passive monitor for the ISP pixel stream. After a start pulse it walks the
// expected frame geometry beat by beat, checks the colour channel sequence
// and the row-end / frame-end flags, keeps a modular checksum per channel
// and counts every kind of error in saturating counters.
//
// Optional feature: define WATCHDOG_EN to add an idle watchdog that ends the
// frame after TIMEOUT_CYC consecutive cycles without a valid beat in RUN.
// Without it, timeout is tied low and RUN waits indefinitely.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   start           one-cycle pulse; clears all state and arms the checker
//   stream          stream bundle (slave modport)
//   busy            high while checking a frame (RUN)
//   done            high after a frame ended, until the next start
//   short_frame     last_pic arrived before the full beat count
//   timeout         watchdog fired
//   color_err_cnt   colour sequence mismatches
//   col_err_cnt     missing or spurious last_col
//   pic_err_cnt     missing or spurious last_pic
//   extra_beat_cnt  valid beats received outside RUN
//   pixel_cnt       completed pixels (all channels seen)
//   checksum        channel k sum at bits [k*CHK_W +: CHK_W]
module isp_stream_checker #(
  parameter int COLOR_DEPTH = 8,
  parameter int IMG_COL     = 1024,
  parameter int IMG_ROW     = 1024,
  parameter int CHANNELS    = 3,
  parameter int CHK_W       = 32,
  parameter int ERR_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  isp_stream_checker_if.slave                  stream,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 short_frame,
  output logic                                 timeout,
  output logic [ERR_W-1:0]                     color_err_cnt,
  output logic [ERR_W-1:0]                     col_err_cnt,
  output logic [ERR_W-1:0]                     pic_err_cnt,
  output logic [ERR_W-1:0]                     extra_beat_cnt,
  output logic [$clog2(IMG_COL*IMG_ROW):0]     pixel_cnt,
  output logic [CHANNELS*CHK_W-1:0]            checksum
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W = (IMG_COL  > 1) ? $clog2(IMG_COL)  : 1;
  localparam int ROW_W = (IMG_ROW  > 1) ? $clog2(IMG_ROW)  : 1;
  localparam int PC_W  = $clog2(IMG_COL*IMG_ROW) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state;
  logic [CH_W-1:0]  ch_idx;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic [CHK_W-1:0] sum_q [CHANNELS];

  logic       beat;
  logic       stray;
  logic       last_ch;
  logic       last_col_pos;
  logic       last_row_pos;
  logic       exp_last_col;
  logic       exp_last_pic;
  logic [1:0] exp_color;
  logic       color_bad;
  logic       col_bad;
  logic       pic_bad;
  logic       frame_end;
  logic       wd_fire;

  // A start pulse always takes priority, so a beat arriving with it is
  // neither checked nor counted as stray.
  assign beat  = (state == S_RUN) && stream.valid_in && !start;
  assign stray = (state != S_RUN) && stream.valid_in && !start;

  assign last_ch      = (ch_idx  == CH_W'(CHANNELS - 1));
  assign last_col_pos = (col_idx == COL_W'(IMG_COL - 1));
  assign last_row_pos = (row_idx == ROW_W'(IMG_ROW - 1));
  assign exp_last_col = last_ch && last_col_pos;
  assign exp_last_pic = exp_last_col && last_row_pos;

  // Three-channel streams cycle RED, GREEN, BLUE (codes 1..3); a single
  // channel stream is raw data tagged VOID.
  always_comb begin
    exp_color = 2'd0;
    if (CHANNELS == 3) begin
      exp_color = 2'(ch_idx) + 2'd1;
    end
  end

  assign color_bad = (stream.color_in != exp_color);
  assign col_bad   = (stream.last_col_in != exp_last_col);
  assign pic_bad   = (stream.last_pic_in != exp_last_pic);

  // The frame ends either when the producer says so or when the geometry
  // says so; a missing flag on the final beat is already counted by pic_bad.
  assign frame_end = stream.last_pic_in || exp_last_pic;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

`ifdef WATCHDOG_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_q;

  // The watchdog fires on the edge that samples the TIMEOUT_CYC-th
  // consecutive idle cycle in RUN.
  assign wd_fire = (state == S_RUN) && !stream.valid_in && !start &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  // Idle run length: only grows while RUN sees no beat; anything else
  // (a beat, a restart, leaving RUN) starts the count over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start || (state != S_RUN) || stream.valid_in || wd_fire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (start) begin
        timeout_q <= 1'b0;
      end else if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Top-level sequencing: IDLE and DONE only leave on start; RUN ends on a
  // frame end beat or a watchdog expiry and restarts in place on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (start) begin
      state <= S_RUN;
    end else if (beat && frame_end) begin
      state <= S_DONE;
    end else if (wd_fire) begin
      state <= S_DONE;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Position within the frame. Colour mismatches do not stall tracking:
  // every beat advances the channel index regardless of its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx    <= '0;
      col_idx   <= '0;
      row_idx   <= '0;
      pixel_cnt <= '0;
    end else if (start) begin
      ch_idx    <= '0;
      col_idx   <= '0;
      row_idx   <= '0;
      pixel_cnt <= '0;
    end else if (beat) begin
      if (last_ch) begin
        ch_idx    <= '0;
        pixel_cnt <= pixel_cnt + PC_W'(1);
        if (last_col_pos) begin
          col_idx <= '0;
          row_idx <= last_row_pos ? '0 : row_idx + ROW_W'(1);
        end else begin
          col_idx <= col_idx + COL_W'(1);
        end
      end else begin
        ch_idx <= ch_idx + CH_W'(1);
      end
    end
  end

  // Error counters and the short-frame flag. Several counters may step on
  // the same beat; all of them stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_err_cnt  <= '0;
      col_err_cnt    <= '0;
      pic_err_cnt    <= '0;
      extra_beat_cnt <= '0;
      short_frame    <= 1'b0;
    end else if (start) begin
      color_err_cnt  <= '0;
      col_err_cnt    <= '0;
      pic_err_cnt    <= '0;
      extra_beat_cnt <= '0;
      short_frame    <= 1'b0;
    end else begin
      if (beat && color_bad) begin
        color_err_cnt <= sat_inc(color_err_cnt);
      end
      if (beat && col_bad) begin
        col_err_cnt <= sat_inc(col_err_cnt);
      end
      if (beat && pic_bad) begin
        pic_err_cnt <= sat_inc(pic_err_cnt);
      end
      if (beat && stream.last_pic_in && !exp_last_pic) begin
        short_frame <= 1'b1;
      end
      if (stray) begin
        extra_beat_cnt <= sat_inc(extra_beat_cnt);
      end
    end
  end

  // Per-channel checksums. The slot is chosen by position, not by the
  // colour tag, so a mislabelled beat still lands where it belongs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sum_q[k] <= '0;
      end
    end else if (start) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sum_q[k] <= '0;
      end
    end else if (beat) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (ch_idx == CH_W'(k)) begin
          sum_q[k] <= sum_q[k] + CHK_W'(stream.pixel_in);
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign checksum[g*CHK_W +: CHK_W] = sum_q[g];
  end

endmodule

// File: tb/tb_isp_stream_checker.sv
// tb_isp_stream_checker
// Drives one shared stream into two checkers (4x2 RGB and 4x2 raw) and
// compares every output of both after every clock against a beat-counting
// reference model, plus directed frames with known totals.
module tb_isp_stream_checker;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  isp_stream_checker_if #(.COLOR_DEPTH(8)) bus ();

  logic        busy3, done3, short3, tout3;
  logic [15:0] cerr3, lerr3, perr3, extra3;
  logic [3:0]  pix3;
  logic [95:0] sum3;

  logic        busy1, done1, short1, tout1;
  logic [15:0] cerr1, lerr1, perr1, extra1;
  logic [3:0]  pix1;
  logic [31:0] sum1;

  isp_stream_checker #(
    .COLOR_DEPTH(8), .IMG_COL(COLS), .IMG_ROW(ROWS), .CHANNELS(3),
    .CHK_W(32), .ERR_W(16), .TIMEOUT_CYC(TO)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stream(bus.slave),
    .busy(busy3), .done(done3), .short_frame(short3), .timeout(tout3),
    .color_err_cnt(cerr3), .col_err_cnt(lerr3), .pic_err_cnt(perr3),
    .extra_beat_cnt(extra3), .pixel_cnt(pix3), .checksum(sum3)
  );

  isp_stream_checker #(
    .COLOR_DEPTH(8), .IMG_COL(COLS), .IMG_ROW(ROWS), .CHANNELS(1),
    .CHK_W(32), .ERR_W(16), .TIMEOUT_CYC(TO)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stream(bus.slave),
    .busy(busy1), .done(done1), .short_frame(short1), .timeout(tout1),
    .color_err_cnt(cerr1), .col_err_cnt(lerr1), .pic_err_cnt(perr1),
    .extra_beat_cnt(extra1), .pixel_cnt(pix1), .checksum(sum1)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: index 0 mirrors the RGB checker, index 1 the raw one.
  // Position is a single running beat number inside the frame.
  bit          m_busy [2];
  bit          m_done [2];
  bit          m_short[2];
  bit          m_tout [2];
  int          m_cerr [2];
  int          m_lerr [2];
  int          m_perr [2];
  int          m_extra[2];
  int          m_pix  [2];
  int          m_beat [2];
  int          m_idle [2];
  logic [31:0] m_sum  [2][3];

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chOf(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic modelClear(input int d);
    m_busy[d] = 0; m_done[d] = 0; m_short[d] = 0; m_tout[d] = 0;
    m_cerr[d] = 0; m_lerr[d] = 0; m_perr[d] = 0; m_extra[d] = 0;
    m_pix[d] = 0; m_beat[d] = 0; m_idle[d] = 0;
    for (int k = 0; k < 3; k++) m_sum[d][k] = 32'd0;
  endtask

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      int n, k, bpr, tot, expc;
      bit elc, elp;
      n   = chOf(d);
      bpr = n * COLS;
      tot = bpr * ROWS;
      if (start) begin
        modelClear(d);
        m_busy[d] = 1;
      end else if (bus.valid_in) begin
        if (!m_busy[d]) begin
          m_extra[d] = sat(m_extra[d]);
        end else begin
          k    = m_beat[d] % n;
          expc = (n == 3) ? k + 1 : 0;
          elc  = ((m_beat[d] + 1) % bpr) == 0;
          elp  = (m_beat[d] + 1) == tot;
          if (int'(bus.color_in) != expc) m_cerr[d] = sat(m_cerr[d]);
          if (bus.last_col_in != elc) m_lerr[d] = sat(m_lerr[d]);
          if (bus.last_pic_in != elp) m_perr[d] = sat(m_perr[d]);
          if (bus.last_pic_in && !elp) m_short[d] = 1;
          m_sum[d][k] = m_sum[d][k] + 32'(bus.pixel_in);
          if (k == n - 1) m_pix[d]++;
          m_beat[d]++;
          m_idle[d] = 0;
          if (bus.last_pic_in || elp) begin
            m_busy[d] = 0;
            m_done[d] = 1;
          end
        end
      end else if (m_busy[d]) begin
`ifdef WATCHDOG_EN
        m_idle[d]++;
        if (m_idle[d] == TO) begin
          m_tout[d] = 1;
          m_busy[d] = 0;
          m_done[d] = 1;
        end
`endif
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("busy3", busy3, m_busy[0]);
    checkOutput("done3", done3, m_done[0]);
    checkOutput("short3", short3, m_short[0]);
    checkOutput("timeout3", tout3, m_tout[0]);
    checkOutput("cerr3", cerr3, m_cerr[0]);
    checkOutput("lerr3", lerr3, m_lerr[0]);
    checkOutput("perr3", perr3, m_perr[0]);
    checkOutput("extra3", extra3, m_extra[0]);
    checkOutput("pix3", pix3, m_pix[0]);
    checkOutput("sum3_r", sum3[31:0], m_sum[0][0]);
    checkOutput("sum3_g", sum3[63:32], m_sum[0][1]);
    checkOutput("sum3_b", sum3[95:64], m_sum[0][2]);
    checkOutput("busy1", busy1, m_busy[1]);
    checkOutput("done1", done1, m_done[1]);
    checkOutput("short1", short1, m_short[1]);
    checkOutput("timeout1", tout1, m_tout[1]);
    checkOutput("cerr1", cerr1, m_cerr[1]);
    checkOutput("lerr1", lerr1, m_lerr[1]);
    checkOutput("perr1", perr1, m_perr[1]);
    checkOutput("extra1", extra1, m_extra[1]);
    checkOutput("pix1", pix1, m_pix[1]);
    checkOutput("sum1", sum1, m_sum[1][0]);
  endtask

  // One clock of stimulus: inputs change just after an edge, the model
  // consumes them, and outputs are compared just after the next edge.
  task automatic applyStimulus(input bit st, input bit v, input logic [7:0] pix,
                               input logic [1:0] col, input bit lc, input bit lp);
    start           = st;
    bus.valid_in    = v;
    bus.pixel_in    = pix;
    bus.color_in    = col;
    bus.last_col_in = lc;
    bus.last_pic_in = lp;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
    start        = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // RGB frame with pixel value equal to the channel code. scen: 0 clean,
  // 1 beat 5 tagged BLUE value 3, 2 last_col moved from beat 12 to beat 6,
  // 3 last_pic on beat 15 followed by beats 16-18.
  task automatic runFrame3(input int scen);
    int nb;
    logic [1:0] c;
    logic [7:0] p;
    bit lc, lp;
    applyStimulus(1, 0, 8'd0, 2'd0, 0, 0);
    nb = (scen == 3) ? 18 : 24;
    for (int i = 1; i <= nb; i++) begin
      c  = 2'(((i - 1) % 3) + 1);
      p  = 8'(c);
      lc = (i % 12) == 0;
      lp = (i == 24);
      if (scen == 1 && i == 5) begin c = 2'd3; p = 8'd3; end
      if (scen == 2 && i == 12) lc = 0;
      if (scen == 2 && i == 6) lc = 1;
      if (scen == 3 && i == 15) lp = 1;
      applyStimulus(0, 1, p, c, lc, lp);
    end
  endtask

  // Raw frame of 8 VOID beats; scen 1 tags beat 3 RED, scen 2 resets the
  // checkers asynchronously after beat 4.
  task automatic runFrame1(input int scen, output int total);
    logic [7:0] p;
    total = 0;
    applyStimulus(1, 0, 8'd0, 2'd0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      p = 8'($urandom);
      total += int'(p);
      applyStimulus(0, 1, p, (scen == 1 && i == 3) ? 2'd1 : 2'd0, (i % 4) == 0, i == 8);
      if (scen == 2 && i == 4) begin
        rst_n = 1'b0;
        #1;
        modelClear(0);
        modelClear(1);
        checkAll();
        checkOutput("rst_busy1", busy1, 1'b0);
        checkOutput("rst_sum1", sum1, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkAll();
        break;
      end
    end
  endtask

  initial begin
    int tot;
    bus.valid_in = 0; bus.pixel_in = 0; bus.color_in = 0;
    bus.last_col_in = 0; bus.last_pic_in = 0;
    modelClear(0);
    modelClear(1);
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    $display("[TB] directed RGB frames");
    runFrame3(0);
    checkOutput("clean_done", done3, 1'b1);
    checkOutput("clean_errs", {cerr3, lerr3, perr3, extra3}, 64'd0);
    checkOutput("clean_pix", pix3, 4'd8);
    checkOutput("clean_sum", sum3, {32'd24, 32'd16, 32'd8});
    runFrame3(1);
    checkOutput("cerr_cnt", cerr3, 16'd1);
    checkOutput("cerr_green", sum3[63:32], 32'd17);
    checkOutput("cerr_done", done3, 1'b1);
    runFrame3(2);
    checkOutput("lcol_cnt", lerr3, 16'd2);
    checkOutput("lcol_pic", perr3, 16'd0);
    checkOutput("lcol_done", done3, 1'b1);
    runFrame3(3);
    checkOutput("early_flags", {done3, short3}, 2'b11);
    checkOutput("early_perr", perr3, 16'd1);
    checkOutput("early_pix", pix3, 4'd5);
    checkOutput("early_extra", extra3, 16'd3);

    $display("[TB] directed raw frames");
    runFrame1(0, tot);
    checkOutput("raw_done", done1, 1'b1);
    checkOutput("raw_sum", sum1, 32'(tot));
    checkOutput("raw_pix", pix1, 4'd8);
    checkOutput("raw_errs", {cerr1, lerr1, perr1}, 48'd0);
    runFrame1(1, tot);
    checkOutput("raw_cerr", cerr1, 16'd1);
    runFrame1(2, tot);

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      applyStimulus(1, 0, 8'd0, 2'd0, 0, 0);
      for (int i = 1; i <= 26; i++) begin
        logic [1:0] c;
        bit lc, lp;
        repeat ($urandom_range(0, 3)) idleCycle();
        c  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(((i - 1) % 3) + 1);
        lc = ((i % 12) == 0) ^ ($urandom_range(0, 19) == 0);
        lp = (i == 24) ^ ($urandom_range(0, 29) == 0);
        applyStimulus($urandom_range(0, 49) == 0, 1, 8'($urandom), c, lc, lp);
      end
    end

    $display("[TB] idle watchdog");
    applyStimulus(1, 0, 8'd0, 2'd0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 8'($urandom), 2'(((i - 1) % 3) + 1), 0, 0);
    end
`ifdef WATCHDOG_EN
    repeat (TO - 1) idleCycle();
    checkOutput("wd_busy_before", busy3, 1'b1);
    idleCycle();
    checkOutput("wd_timeout", tout3, 1'b1);
    checkOutput("wd_done", done3, 1'b1);
`else
    repeat (110) idleCycle();
    checkOutput("nowd_busy", busy3, 1'b1);
    checkOutput("nowd_timeout", tout3, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/isp_stream_checker.md
Name: isp_stream_checker

Overview:
- Synthesizable, parametrised monitor for the ISP pixel stream (pixel/valid/color/last_col/last_pic).
- Checks channel ordering, row-end and frame-end flag placement, and beat counts against the configured geometry.
- Accumulates per-channel checksums and saturating error counters.
- Instantiated on any stage boundary (raw input or RGB output) for on-chip and bench self-checking.

Parameters:
- COLOR_DEPTH, 8, pixel width
- IMG_COL, 1024, pixels per row
- IMG_ROW, 1024, rows per frame
- CHANNELS, 3, beats per pixel; 3 = R,G,B sequence, 1 = raw/VOID stream
- CHK_W, 32, per-channel checksum width
- ERR_W, 16, error counter width
- TIMEOUT_CYC, 4096, watchdog limit; used only with WATCHDOG_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears state and arms checker
- pixel_in  in  COLOR_DEPTH  stream data
- valid_in  in  1  beat qualifier
- color_in  in  2  0=VOID 1=RED 2=GREEN 3=BLUE
- last_col_in  in  1  last beat of a row
- last_pic_in  in  1  last beat of a frame
- busy  out  1  high in RUN
- done  out  1  level; high in DONE until next start
- short_frame  out  1  last_pic seen before full beat count
- timeout  out  1  watchdog fired (0 without WATCHDOG_EN)
- color_err_cnt  out  ERR_W  color mismatches
- col_err_cnt  out  ERR_W  missing or spurious last_col
- pic_err_cnt  out  ERR_W  missing or spurious last_pic
- extra_beat_cnt  out  ERR_W  valid beats outside RUN
- pixel_cnt  out  log2(IMG_COL*IMG_ROW)+1  completed pixels
- checksum  out  CHANNELS*CHK_W  channel k at bits [k*CHK_W +: CHK_W]; modular sum of pixel_in

Behaviour:
- Reset, any time including mid-frame: state IDLE; all outputs 0; internal indices 0.
- States:
  - IDLE --start--> RUN.
  - RUN --last_pic_in beat, or final expected beat--> DONE.
  - DONE --start--> RUN.
  - start in RUN restarts: counters, checksums and flags clear; state stays RUN.
- Positional tracking in RUN:
  - ch_idx 0..CHANNELS-1, col_idx 0..IMG_COL-1, row_idx 0..IMG_ROW-1.
  - Each valid beat advances ch_idx.
  - ch_idx wrap increments col_idx and pixel_cnt.
  - col_idx wrap increments row_idx.
- Expected color:
  - CHANNELS=3: RED, GREEN, BLUE for ch_idx 0,1,2.
  - CHANNELS=1: VOID.
  - Mismatch: color_err_cnt+1. Position still advances, and the checksum slot is chosen by ch_idx, not color_in.
- Row-end flag: expected last_col = (ch_idx==CHANNELS-1 && col_idx==IMG_COL-1). last_col_in != expected → col_err_cnt+1.
- Frame-end flag: expected last_pic = expected last_col && row_idx==IMG_ROW-1. last_pic_in != expected → pic_err_cnt+1.
- Early last_pic_in: enter DONE, short_frame=1.
- Final expected beat without last_pic_in: pic_err_cnt+1, enter DONE.
- One beat may raise several counters in the same cycle.
- Counters saturate at all-ones. Checksums wrap modulo 2^CHK_W.
- Latency: all outputs registered, updated on the clk edge that samples the beat. done/busy change on the same edge as the state.
- valid_in in IDLE or DONE: extra_beat_cnt+1; nothing else changes.
- start and valid_in in the same cycle: start wins, beat is discarded and not counted.
- valid_in low: no state change (except the watchdog).

Optional Feature:
- Macro WATCHDOG_EN.
- Defined: an idle counter in RUN counts consecutive cycles with valid_in=0 and resets on every valid beat. On reaching TIMEOUT_CYC: timeout=1, state DONE on that edge.
- Undefined: no counter, timeout tied 0; RUN waits indefinitely.

Test Plan:
- IMG_COL=4, IMG_ROW=2, CHANNELS=3: start, then 24 clean beats with R=1, G=2, B=3 and correct flags (last_col on beats 12 and 24, last_pic on 24) -> done=1 after beat 24; all error counters 0; pixel_cnt=8; checksums 8/16/24.
- Same frame, beat 5 color BLUE instead of GREEN, value 3 -> color_err_cnt=1; green checksum=17; other outputs as clean case.
- last_col omitted on beat 12 and asserted on beat 6 -> col_err_cnt=2; done after beat 24; pic_err_cnt=0.
- last_pic asserted on beat 15 -> done, short_frame=1, pic_err_cnt=1, pixel_cnt=5; beats 16-18 after -> extra_beat_cnt=3.
- CHANNELS=1, 8 VOID beats -> pass, checksum = sum of values. Same with beat 3 color RED -> color_err_cnt=1. Reset asserted after beat 4 -> all outputs 0, state IDLE.
- WATCHDOG_EN, TIMEOUT_CYC=16: 10 beats, then valid_in held low -> timeout=1 and done=1 on the 16th idle cycle. Without the macro, busy stays 1 for over 100 idle cycles.
